decode_stage: RTL and testbench

//  Second pipeline stage. Consumes the IF/ID latch: instr_IFID, PC_IFID, PC2_IFID, halt_IFID.

---
 rtl/decode_stage_pkg.sv | 135 +++++++++++++
 rtl/decode_stage_regfile_bypass.sv | 41 ++++
 rtl/decode_stage.sv | 149 ++++++++++++++
 tb/tb_decode_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_stage_pkg                                                   |
// | Opcode map, decode classes and the decode/extend helper functions. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package decode_stage_pkg;

    localparam int          INSTR_W      = 16;
    localparam int          REG_W        = 3;
    localparam logic [15:0] NOP_ENCODING = 16'h0800;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_SHIFT = 5'b11010;
    localparam logic [4:0] OP_ALU   = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM5_S   = 3'd1,
        IMM5_Z   = 3'd2,
        IMM8_S   = 3'd3,
        IMM8_Z   = 3'd4,
        DISP11_S = 3'd5
    } imm_class_e;

    typedef enum logic [2:0] {
        DST_NONE = 3'd0,
        DST_RD_R = 3'd1,
        DST_RD_I = 3'd2,
        DST_RS   = 3'd3,
        DST_R7   = 3'd4
    } dest_class_e;

    typedef struct packed {
        dest_class_e dest;
        imm_class_e  imm;
        logic        uses_rs;
        logic        uses_rt;
        logic        mem_read;
        logic        mem_write;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [4:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_HALT, OP_NOP: c = '0;
            OP_ADDI, OP_SUBI: begin
                c.dest = DST_RD_I; c.imm = IMM5_S; c.uses_rs = 1'b1;
            end
            OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                c.dest = DST_RD_I; c.imm = IMM5_Z; c.uses_rs = 1'b1;
            end
            OP_LD: begin
                c.dest = DST_RD_I; c.imm = IMM5_S; c.uses_rs = 1'b1; c.mem_read = 1'b1;
            end
            OP_ST: begin
                c.imm = IMM5_S; c.uses_rs = 1'b1; c.uses_rt = 1'b1; c.mem_write = 1'b1;
            end
            // Store-with-update writes the incremented base back into Rs
            OP_STU: begin
                c.dest = DST_RS; c.imm = IMM5_S;
                c.uses_rs = 1'b1; c.uses_rt = 1'b1; c.mem_write = 1'b1;
            end
            OP_BTR: begin
                c.dest = DST_RD_R; c.uses_rs = 1'b1;
            end
            OP_SHIFT, OP_ALU, OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                c.dest = DST_RD_R; c.uses_rs = 1'b1; c.uses_rt = 1'b1;
            end
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_JR: begin
                c.imm = IMM8_S; c.uses_rs = 1'b1;
            end
            OP_LBI:  begin c.dest = DST_RS; c.imm = IMM8_S; end
            OP_SLBI: begin c.dest = DST_RS; c.imm = IMM8_Z; c.uses_rs = 1'b1; end
            OP_J:    c.imm = DISP11_S;
            OP_JAL:  begin c.dest = DST_R7; c.imm = DISP11_S; end
            OP_JALR: begin c.dest = DST_R7; c.imm = IMM8_S; c.uses_rs = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [INSTR_W-1:0] extend_imm(input logic [INSTR_W-1:0] instr,
                                                      input imm_class_e cls);
        case (cls)
            IMM5_S:   return {{11{instr[4]}}, instr[4:0]};
            IMM5_Z:   return {11'd0, instr[4:0]};
            IMM8_S:   return {{8{instr[7]}}, instr[7:0]};
            IMM8_Z:   return {8'd0, instr[7:0]};
            DISP11_S: return {{5{instr[10]}}, instr[10:0]};
            default:  return '0;
        endcase
    endfunction

    function automatic logic [REG_W-1:0] dest_reg(input logic [INSTR_W-1:0] instr,
                                                  input dest_class_e cls);
        case (cls)
            DST_RD_R: return instr[4:2];
            DST_RD_I: return instr[7:5];
            DST_RS:   return instr[10:8];
            DST_R7:   return 3'd7;
            default:  return '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_regfile_bypass.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_stage_regfile_bypass                                        |
// | 2R/1W register file with write-before-read bypass, async reset.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module decode_stage_regfile_bypass #(
    parameter int  DATA_W = 16,
    parameter int  NREG   = 8,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_valid,
    input  logic              i_wr_commit,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr1,
    input  logic [AW-1:0]     i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2
);

    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_valid && i_wr_commit) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Bypass is not gated by commit: when the pipe is frozen nothing samples it
    assign o_rd_data1 = (i_wr_valid && (i_wr_addr == i_rd_addr1)) ? i_wr_data : r_mem[i_rd_addr1];
    assign o_rd_data2 = (i_wr_valid && (i_wr_addr == i_rd_addr2)) ? i_wr_data : r_mem[i_rd_addr2];

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_stage                                                       |
// | ID stage: register read, decode, load-use hazard, ID/EX register.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int                 DATA_W    = 16,
    parameter int                 NREG      = 8,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic [INSTR_W-1:0] instr_IFID,
    input  logic [DATA_W-1:0]  PC_IFID,
    input  logic [DATA_W-1:0]  PC2_IFID,
    input  logic               halt_IFID,
    input  logic               takeBranch_EXMEM,
    input  logic               wbEn,
    input  logic [REG_W-1:0]   wbReg,
    input  logic [DATA_W-1:0]  wbData,
    output logic               stallCtrl,
    output logic               startStall,
    output logic [DATA_W-1:0]  rdata1_IDEX,
    output logic [DATA_W-1:0]  rdata2_IDEX,
    output logic [DATA_W-1:0]  imm_IDEX,
    output logic [REG_W-1:0]   wrReg_IDEX,
    output logic               regWrite_IDEX,
    output logic               memRead_IDEX,
    output logic               memWrite_IDEX,
    output logic [INSTR_W-1:0] instr_IDEX,
    output logic [DATA_W-1:0]  PC_IDEX,
    output logic [DATA_W-1:0]  PC2_IDEX,
    output logic               halt_IDEX
);

    ctrl_t              w_ctrl;
    logic [REG_W-1:0]   w_rs;
    logic [REG_W-1:0]   w_rt;
    logic [REG_W-1:0]   w_dest;
    logic [DATA_W-1:0]  w_imm;
    logic [DATA_W-1:0]  w_rdata1;
    logic [DATA_W-1:0]  w_rdata2;
    logic               w_hit;
    logic               w_bubble;

    logic [DATA_W-1:0]  r_rdata1;
    logic [DATA_W-1:0]  r_rdata2;
    logic [DATA_W-1:0]  r_imm;
    logic [REG_W-1:0]   r_wr_reg;
    logic               r_reg_write;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [INSTR_W-1:0] r_instr;
    logic [DATA_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_pc2;
    logic               r_halt;
    logic               r_stall_q;

    assign w_ctrl = decode_op(instr_IFID[15:11]);
    assign w_rs   = instr_IFID[10:8];
    assign w_rt   = instr_IFID[7:5];
    assign w_dest = dest_reg(instr_IFID, w_ctrl.dest);
    assign w_imm  = extend_imm(instr_IFID, w_ctrl.imm);

    decode_stage_regfile_bypass #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_wr_valid  (wbEn),
        .i_wr_commit (freeze),
        .i_wr_addr   (wbReg),
        .i_wr_data   (wbData),
        .i_rd_addr1  (w_rs),
        .i_rd_addr2  (w_rt),
        .o_rd_data1  (w_rdata1),
        .o_rd_data2  (w_rdata2)
    );

    // Only loads stall; everything else is forwarded downstream
    assign w_hit      = (w_ctrl.uses_rs && (r_wr_reg == w_rs)) ||
                        (w_ctrl.uses_rt && (r_wr_reg == w_rt));
    assign stallCtrl  = r_mem_read && r_reg_write && !takeBranch_EXMEM && w_hit;
    assign startStall = stallCtrl && !r_stall_q;
    assign w_bubble   = stallCtrl || takeBranch_EXMEM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_q   <= 1'b0;
            r_rdata1    <= '0;
            r_rdata2    <= '0;
            r_imm       <= '0;
            r_wr_reg    <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_instr     <= NOP_INSTR;
            r_pc        <= '0;
            r_pc2       <= '0;
            r_halt      <= 1'b0;
        end else if (freeze) begin
            r_stall_q <= stallCtrl;
            if (w_bubble) begin
                r_rdata1    <= '0;
                r_rdata2    <= '0;
                r_imm       <= '0;
                r_wr_reg    <= '0;
                r_reg_write <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_instr     <= NOP_INSTR;
                r_pc        <= '0;
                r_pc2       <= '0;
                r_halt      <= 1'b0;
            end else begin
                r_rdata1    <= w_rdata1;
                r_rdata2    <= w_rdata2;
                r_imm       <= w_imm;
                r_wr_reg    <= w_dest;
                r_reg_write <= (w_ctrl.dest != DST_NONE);
                r_mem_read  <= w_ctrl.mem_read;
                r_mem_write <= w_ctrl.mem_write;
                r_instr     <= instr_IFID;
                r_pc        <= PC_IFID;
                r_pc2       <= PC2_IFID;
                r_halt      <= halt_IFID;
            end
        end
    end

    assign rdata1_IDEX   = r_rdata1;
    assign rdata2_IDEX   = r_rdata2;
    assign imm_IDEX      = r_imm;
    assign wrReg_IDEX    = r_wr_reg;
    assign regWrite_IDEX = r_reg_write;
    assign memRead_IDEX  = r_mem_read;
    assign memWrite_IDEX = r_mem_write;
    assign instr_IDEX    = r_instr;
    assign PC_IDEX       = r_pc;
    assign PC2_IDEX      = r_pc2;
    assign halt_IDEX     = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_decode_stage                                                    |
// | Directed scenarios plus randomized run against a behavioural model.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic [15:0] instr_IFID;
    logic [15:0] PC_IFID;
    logic [15:0] PC2_IFID;
    logic        halt_IFID;
    logic        takeBranch_EXMEM;
    logic        wbEn;
    logic [2:0]  wbReg;
    logic [15:0] wbData;
    logic        stallCtrl;
    logic        startStall;
    logic [15:0] rdata1_IDEX;
    logic [15:0] rdata2_IDEX;
    logic [15:0] imm_IDEX;
    logic [2:0]  wrReg_IDEX;
    logic        regWrite_IDEX;
    logic        memRead_IDEX;
    logic        memWrite_IDEX;
    logic [15:0] instr_IDEX;
    logic [15:0] PC_IDEX;
    logic [15:0] PC2_IDEX;
    logic        halt_IDEX;

    decode_stage dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .instr_IFID       (instr_IFID),
        .PC_IFID          (PC_IFID),
        .PC2_IFID         (PC2_IFID),
        .halt_IFID        (halt_IFID),
        .takeBranch_EXMEM (takeBranch_EXMEM),
        .wbEn             (wbEn),
        .wbReg            (wbReg),
        .wbData           (wbData),
        .stallCtrl        (stallCtrl),
        .startStall       (startStall),
        .rdata1_IDEX      (rdata1_IDEX),
        .rdata2_IDEX      (rdata2_IDEX),
        .imm_IDEX         (imm_IDEX),
        .wrReg_IDEX       (wrReg_IDEX),
        .regWrite_IDEX    (regWrite_IDEX),
        .memRead_IDEX     (memRead_IDEX),
        .memWrite_IDEX    (memWrite_IDEX),
        .instr_IDEX       (instr_IDEX),
        .PC_IDEX          (PC_IDEX),
        .PC2_IDEX         (PC2_IDEX),
        .halt_IDEX        (halt_IDEX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] imm;
        logic [2:0]  wr;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [15:0] ins;
        logic [15:0] pc;
        logic [15:0] pc2;
        logic        halt;
    } idex_t;

    idex_t       m_idex;
    logic [15:0] m_rf [8];
    logic        m_stall_q;
    int          checks   = 0;
    int          failures = 0;

    function automatic idex_t m_bubble();
        idex_t b;
        b = '0;
        b.ins = 16'h0800;
        return b;
    endfunction

    function automatic idex_t obs();
        return {rdata1_IDEX, rdata2_IDEX, imm_IDEX, wrReg_IDEX, regWrite_IDEX, memRead_IDEX,
                memWrite_IDEX, instr_IDEX, PC_IDEX, PC2_IDEX, halt_IDEX};
    endfunction

    function automatic void m_reset();
        m_idex    = m_bubble();
        m_stall_q = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    endfunction

    // ISA rules: which fields name the destination, which sources are read, immediate width/sign
    function automatic void m_decode(input logic [15:0] ins, output logic has_dst,
                                     output logic [2:0] dst, output logic [15:0] imm,
                                     output logic urs, output logic urt);
        logic [4:0] op;
        int         w;
        bit         sgn;
        int         raw;
        op = ins[15:11];
        has_dst = 1'b0; dst = 3'd0; urs = 1'b0; urt = 1'b0; w = 0; sgn = 1'b0;
        if (op inside {5'b11011, 5'b11010, 5'b11100, 5'b11101, 5'b11110, 5'b11111}) begin
            has_dst = 1'b1; dst = ins[4:2]; urs = 1'b1; urt = 1'b1;
        end else if (op == 5'b11001) begin
            has_dst = 1'b1; dst = ins[4:2]; urs = 1'b1;
        end else if (op inside {5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10100, 5'b10101,
                                5'b10110, 5'b10111, 5'b10001}) begin
            has_dst = 1'b1; dst = ins[7:5]; urs = 1'b1;
        end else if (op == 5'b10000) begin
            urs = 1'b1; urt = 1'b1;
        end else if (op == 5'b10011) begin
            has_dst = 1'b1; dst = ins[10:8]; urs = 1'b1; urt = 1'b1;
        end else if (op == 5'b11000) begin
            has_dst = 1'b1; dst = ins[10:8];
        end else if (op == 5'b10010) begin
            has_dst = 1'b1; dst = ins[10:8]; urs = 1'b1;
        end else if (op inside {5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b00101}) begin
            urs = 1'b1;
        end else if (op == 5'b00111) begin
            has_dst = 1'b1; dst = 3'd7; urs = 1'b1;
        end else if (op == 5'b00110) begin
            has_dst = 1'b1; dst = 3'd7;
        end
        if (op inside {5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011}) begin
            w = 5; sgn = 1'b1;
        end else if (op inside {5'b01010, 5'b01011, 5'b10100, 5'b10101, 5'b10110, 5'b10111}) begin
            w = 5;
        end else if (op inside {5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000, 5'b00101,
                                5'b00111}) begin
            w = 8; sgn = 1'b1;
        end else if (op == 5'b10010) begin
            w = 8;
        end else if (op inside {5'b00100, 5'b00110}) begin
            w = 11; sgn = 1'b1;
        end
        raw = (w == 0) ? 0 : (int'(ins) & ((1 << w) - 1));
        if (sgn && raw >= (1 << (w - 1))) raw = raw - (1 << w);
        imm = 16'(raw);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] r);
        return (wbEn && wbReg == r) ? wbData : m_rf[r];
    endfunction

    function automatic logic m_stall();
        logic hd; logic [2:0] d; logic [15:0] im; logic urs; logic urt;
        m_decode(instr_IFID, hd, d, im, urs, urt);
        return m_idex.mr && m_idex.rw && !takeBranch_EXMEM &&
               ((urs && m_idex.wr == instr_IFID[10:8]) || (urt && m_idex.wr == instr_IFID[7:5]));
    endfunction

    function automatic idex_t m_entry();
        idex_t e; logic hd; logic [2:0] d; logic [15:0] im; logic urs; logic urt;
        m_decode(instr_IFID, hd, d, im, urs, urt);
        e.rd1  = m_read(instr_IFID[10:8]);
        e.rd2  = m_read(instr_IFID[7:5]);
        e.imm  = im;
        e.wr   = hd ? d : 3'd0;
        e.rw   = hd;
        e.mr   = (instr_IFID[15:11] == 5'b10001);
        e.mw   = (instr_IFID[15:11] inside {5'b10000, 5'b10011});
        e.ins  = instr_IFID;
        e.pc   = PC_IFID;
        e.pc2  = PC2_IFID;
        e.halt = halt_IFID;
        return e;
    endfunction

    // One clock edge: the model's next state is taken from the pre-edge inputs
    task automatic tick();
        idex_t       nxt;
        logic        nstall;
        logic        we;
        logic [2:0]  wr;
        logic [15:0] wd;
        nxt    = m_idex;
        nstall = m_stall_q;
        we     = freeze && wbEn;
        wr     = wbReg;
        wd     = wbData;
        if (freeze) begin
            nstall = m_stall();
            nxt    = (m_stall() || takeBranch_EXMEM) ? m_bubble() : m_entry();
        end
        @(posedge clk);
        #1;
        m_idex    = nxt;
        m_stall_q = nstall;
        if (we) m_rf[wr] = wd;
    endtask

    task automatic set_instr(input logic [15:0] ins, input logic [15:0] pc);
        instr_IFID = ins;
        PC_IFID    = pc;
        PC2_IFID   = pc + 16'd2;
        halt_IFID  = (ins == 16'h0000);
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b1; takeBranch_EXMEM = 1'b0;
        wbEn = 1'b0; wbReg = 3'd0; wbData = 16'h0000;
        set_instr(16'h0800, 16'h0000);
        m_reset();
        #12;
        checks++; if (obs() !== m_bubble()) begin failures++;
            $display("FAIL reset_idex got=%h exp=%h", obs(), m_bubble()); end
        checks++; if (stallCtrl !== 1'b0 || startStall !== 1'b0) begin failures++;
            $display("FAIL reset_stall got=%b%b exp=00", stallCtrl, startStall); end
        rst = 1'b0;
        set_instr(16'hD954, 16'h0010);
        tick();
        checks++; if (rdata1_IDEX !== 16'h0 || rdata2_IDEX !== 16'h0) begin failures++;
            $display("FAIL reset_rf got=%h/%h exp=0/0", rdata1_IDEX, rdata2_IDEX); end
        checks++; if (instr_IDEX !== 16'hD954 || wrReg_IDEX !== 3'd5) begin failures++;
            $display("FAIL first_issue got=%h/%0d exp=d954/5", instr_IDEX, wrReg_IDEX); end
    endtask

    task automatic test_load_use();
        set_instr(16'h8C20, 16'h0100);
        #1;
        checks++; if (stallCtrl !== 1'b0) begin failures++;
            $display("FAIL lu_nostall got=%b exp=0", stallCtrl); end
        tick();
        checks++; if (memRead_IDEX !== 1'b1 || wrReg_IDEX !== 3'd1 || regWrite_IDEX !== 1'b1) begin
            failures++; $display("FAIL lu_load got=%b/%0d/%b exp=1/1/1",
                                 memRead_IDEX, wrReg_IDEX, regWrite_IDEX); end
        set_instr(16'hD968, 16'h0102);
        #1;
        checks++; if (stallCtrl !== 1'b1 || startStall !== 1'b1) begin failures++;
            $display("FAIL lu_stall got=%b%b exp=11", stallCtrl, startStall); end
        tick();
        checks++; if (obs() !== m_bubble()) begin failures++;
            $display("FAIL lu_bubble got=%h exp=%h", obs(), m_bubble()); end
        #1;
        checks++; if (stallCtrl !== 1'b0 || startStall !== 1'b0) begin failures++;
            $display("FAIL lu_one_cycle got=%b%b exp=00", stallCtrl, startStall); end
        tick();
        checks++; if (instr_IDEX !== 16'hD968 || wrReg_IDEX !== 3'd2 || PC_IDEX !== 16'h0102) begin
            failures++; $display("FAIL lu_issue got=%h/%0d/%h exp=d968/2/0102",
                                 instr_IDEX, wrReg_IDEX, PC_IDEX); end
    endtask

    task automatic test_flush();
        set_instr(16'h8C20, 16'h0200);
        tick();
        set_instr(16'hD968, 16'h0202);
        takeBranch_EXMEM = 1'b1;
        #1;
        checks++; if (stallCtrl !== 1'b0 || startStall !== 1'b0) begin failures++;
            $display("FAIL flush_stall got=%b%b exp=00", stallCtrl, startStall); end
        tick();
        checks++; if (obs() !== m_bubble()) begin failures++;
            $display("FAIL flush_bubble got=%h exp=%h", obs(), m_bubble()); end
        takeBranch_EXMEM = 1'b0;
    endtask

    task automatic test_bypass();
        wbEn = 1'b1; wbReg = 3'd3; wbData = 16'hBEEF;
        set_instr(16'hDB10, 16'h0300);
        tick();
        checks++; if (rdata1_IDEX !== 16'hBEEF) begin failures++;
            $display("FAIL bypass got=%h exp=beef", rdata1_IDEX); end
        wbEn = 1'b0;
        tick();
        checks++; if (rdata1_IDEX !== 16'hBEEF || obs() !== m_idex) begin failures++;
            $display("FAIL bypass_landed got=%h exp=%h", obs(), m_idex); end
    endtask

    task automatic test_immediates();
        logic [15:0] ins_t [6] = '{16'h4230, 16'h5A30, 16'h3400, 16'hC580, 16'h9580, 16'h0000};
        logic [15:0] imm_t [6] = '{16'hFFF0, 16'h0010, 16'hFC00, 16'hFF80, 16'h0080, 16'h0000};
        logic [2:0]  wr_t  [6] = '{3'd1, 3'd1, 3'd7, 3'd5, 3'd5, 3'd0};
        logic        rw_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_instr(ins_t[i], 16'h0400 + 16'(2 * i));
            tick();
            checks++;
            if (imm_IDEX !== imm_t[i] || wrReg_IDEX !== wr_t[i] || regWrite_IDEX !== rw_t[i] ||
                halt_IDEX !== (ins_t[i] == 16'h0000) || memRead_IDEX !== 1'b0) begin
                failures++;
                $display("FAIL imm_%h got=%h/%0d/%b/%b exp=%h/%0d/%b", ins_t[i], imm_IDEX,
                         wrReg_IDEX, regWrite_IDEX, halt_IDEX, imm_t[i], wr_t[i], rw_t[i]);
            end
        end
    endtask

    task automatic test_freeze();
        wbEn = 1'b1; wbReg = 3'd5; wbData = 16'h5555;
        set_instr(16'h8C20, 16'h0500);
        tick();
        freeze = 1'b0; wbData = 16'h1234;
        set_instr(16'hD968, 16'h0502);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stallCtrl !== 1'b1 || startStall !== 1'b1) begin failures++;
                $display("FAIL frz_stall_%0d got=%b%b exp=11", i, stallCtrl, startStall); end
            tick();
            checks++; if (instr_IDEX !== 16'h8C20 || obs() !== m_idex) begin failures++;
                $display("FAIL frz_hold_%0d got=%h exp=%h", i, obs(), m_idex); end
        end
        freeze = 1'b1; wbEn = 1'b0;
        set_instr(16'hDD10, 16'h0504);
        tick();
        checks++; if (rdata1_IDEX !== 16'h5555) begin failures++;
            $display("FAIL frz_rf_held got=%h exp=5555", rdata1_IDEX); end
        wbEn = 1'b1;
        tick();
        wbEn = 1'b0;
        tick();
        checks++; if (rdata1_IDEX !== 16'h1234) begin failures++;
            $display("FAIL frz_write_lands got=%h exp=1234", rdata1_IDEX); end
    endtask

    task automatic test_reset_mid_stall();
        set_instr(16'h8C20, 16'h0600);
        tick();
        set_instr(16'hD968, 16'h0602);
        #1;
        checks++; if (stallCtrl !== 1'b1) begin failures++;
            $display("FAIL rms_pre got=%b exp=1", stallCtrl); end
        rst = 1'b1;
        #1;
        m_reset();
        checks++; if (stallCtrl !== 1'b0 || startStall !== 1'b0 || obs() !== m_bubble()) begin
            failures++; $display("FAIL rms_clear got=%b%b %h exp=00 %h",
                                 stallCtrl, startStall, obs(), m_bubble()); end
        rst = 1'b0;
        set_instr(16'hDD10, 16'h0604);
        tick();
        checks++; if (rdata1_IDEX !== 16'h0000) begin failures++;
            $display("FAIL rms_rf got=%h exp=0000", rdata1_IDEX); end
    endtask

    task automatic test_random();
        logic        hold;
        logic        exp_stall;
        logic [15:0] ins;
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                ins = {($urandom_range(0, 3) == 0) ? 5'b10001 : 5'($urandom), 11'($urandom)};
                set_instr(ins, 16'($urandom) & 16'hFFFE);
            end
            freeze           = ($urandom_range(0, 9) != 0);
            takeBranch_EXMEM = ($urandom_range(0, 9) == 0);
            wbEn             = 1'($urandom);
            wbReg            = 3'($urandom);
            wbData           = 16'($urandom);
            #1;
            exp_stall = m_stall();
            checks++; if (stallCtrl !== exp_stall || startStall !== (exp_stall && !m_stall_q)) begin
                failures++; $display("FAIL rnd_stall_%0d got=%b%b exp=%b%b", i, stallCtrl,
                                     startStall, exp_stall, exp_stall && !m_stall_q); end
            hold = exp_stall || !freeze;
            tick();
            checks++; if (obs() !== m_idex) begin failures++;
                $display("FAIL rnd_idex_%0d got=%h exp=%h", i, obs(), m_idex); end
        end
        freeze = 1'b1; takeBranch_EXMEM = 1'b0; wbEn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_flush();
        test_bypass();
        test_immediates();
        test_freeze();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
